mem_wait_slave: RTL
===================

// Module: mem_wait_slave
// PURPOSE
//  Memory slave that responds to the valid/ready/wr_rd memory bus driven by the UVM memory agent.
//  It sits directly downstream of the bus interface and is the DUT behind it.
//  Accepts one read or write per handshake and inserts a programmable number of wait states.
//  Read data is returned on rdata in the same cycle that ready is asserted.
// PARAMETERS
//  WIDTH        16               data width in bits
//  DEPTH        64               number of words in storage
//  ADDR_WIDTH   $clog2(DEPTH)    address width (derived; do not override)
//  WAIT_CYCLES  2                wait states between request capture and ready (0 allowed)
// PORTS
//  clk_i   in   1           clock; all state changes on posedge
//  rst_i   in   1           asynchronous reset, active-low (0 = reset)
//  valid   in   1           master request valid; held until valid&&ready is sampled
//  wr_rd   in   1           1 = write, 0 = read; qualified by valid
//  addr    in   ADDR_WIDTH  word address; qualified by valid
//  wdata   in   WIDTH       write data; qualified by valid && wr_rd
//  ready   out  1           one-cycle completion strobe; transfer occurs when valid && ready
//  rdata   out  WIDTH       read data; meaningful only while ready=1 for a read
// BEHAVIOUR
//  Reset (rst_i=0, asynchronous): FSM=IDLE, ready=0, rdata=0, wait counter=0, latched request=0,
//   all storage words=0. An in-flight request is dropped with no write and no ready.
//  FSM states:
//   IDLE: ready=0. If valid=1 at a posedge, latch wr_rd/addr/wdata and go to WAIT, cnt=WAIT_CYCLES-1.
//    If WAIT_CYCLES==0, go straight to RESP instead.
//   WAIT: ready=0. cnt decrements each cycle; when cnt==0, go to RESP.
//    valid/addr/wdata changes during WAIT are ignored; only the latched copy is used.
//   RESP: ready=1 for exactly one cycle, then return to IDLE unconditionally.
//    Write: mem[latched addr] <= latched wdata at the posedge ending RESP.
//    Read: rdata is registered on entry to RESP from mem[latched addr], holds its value after RESP,
//     and is not cleared.
//  Latency: valid first seen at edge N -> ready high during cycle N+WAIT_CYCLES+1.
//   Minimum spacing between ready pulses is WAIT_CYCLES+2 cycles.
//  Back-to-back: valid still high in the IDLE cycle after RESP is treated as a new request.
//   The master must deassert valid or change the request after sampling ready.
//  Read-after-write to the same address returns the new data, because the write commits before
//   the next request can be captured.
//  Out of range: when DEPTH is not a power of 2, addr>=DEPTH writes are discarded and reads
//   return 0; ready still pulses.
//  Address wrap: none. addr is a direct index.
//  rdata is unchanged by writes.
// STRUCTURE
//  mem_pkg: WIDTH/DEPTH defaults and the state enum typedef {IDLE, WAIT, RESP} state_e.
//  Sub-module mem_array: DEPTH x WIDTH storage with one synchronous write port, a combinational
//   read port and async reset clear. mem_wait_slave contains the FSM, wait counter and request latch.
// TESTING
//  1. Reset, then write addr=5 wdata=16'hA5A5 with WAIT_CYCLES=2 -> ready is high exactly one cycle,
//     3 cycles after valid is sampled.
//  2. Read addr=5 after test 1 -> rdata=16'hA5A5 while ready=1. Read addr=6 -> rdata=16'h0000.
//  3. WAIT_CYCLES=0 build: write/read addr=63 data=16'hFFFF -> ready in the cycle after capture,
//     and the readback matches.
//  4. During WAIT, change addr to 7 and wdata to 16'h1234 -> the original addr/data are written,
//     and mem[7] is unchanged.
//  5. Assert rst_i=0 mid-WAIT of a write to addr=10 -> ready stays 0, a later read of addr=10
//     returns 0, and the FSM is in IDLE.
//  6. Hold valid high for 3 consecutive writes to addr 0,1,2 -> ready pulses spaced WAIT_CYCLES+2
//     cycles apart, and all three words read back correctly.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared defaults and FSM state type for the wait-state memory slave.
package mem_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_wait_slave_if.sv
// valid/ready/wr_rd memory bus between a master and the wait-state slave.
interface mem_wait_slave_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 6
);

  logic                  valid;
  logic                  wr_rd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WIDTH-1:0]      wdata;
  logic                  ready;
  logic [WIDTH-1:0]      rdata;

  modport master (
    output valid, wr_rd, addr, wdata,
    input  ready, rdata
  );

  modport slave (
    input  valid, wr_rd, addr, wdata,
    output ready, rdata
  );

endinterface

// File: rtl/mem_array.sv
// DEPTH x WIDTH storage: one synchronous write port, one combinational read port,
// cleared by the asynchronous reset. Out-of-range writes are dropped, reads return 0.
module mem_array #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam bit POW2 = (DEPTH == (1 << ADDR_WIDTH));

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic wr_in_range;
  logic rd_in_range;

  assign wr_in_range = POW2 || (int'(waddr) < DEPTH);
  assign rd_in_range = POW2 || (int'(raddr) < DEPTH);

  // NOTE: every word is cleared on reset, so this storage maps to flops rather than a RAM macro.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we && wr_in_range) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = rd_in_range ? mem_q[raddr] : '0;

endmodule

// File: rtl/mem_wait_slave.sv
// Memory slave: latches one request per handshake, waits WAIT_CYCLES, then pulses ready
// for one cycle with read data registered alongside.
module mem_wait_slave
  import mem_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  mem_wait_slave_if.slave bus
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;

  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [WIDTH-1:0]      mem_rdata;
  logic                  mem_we;

  // With zero wait states the read happens in the capture cycle, before the latch holds the address.
  assign mem_raddr = (state_q == IDLE) ? bus.addr : addr_q;
  assign mem_we    = (state_q == RESP) && wr_q;

  mem_array #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem_array (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .we   (mem_we),
    .waddr(addr_q),
    .wdata(wdata_q),
    .raddr(mem_raddr),
    .rdata(mem_rdata)
  );

  // NOTE: every signal gets a default first so no path through the case leaves a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.valid) begin
          wr_d    = bus.wr_rd;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            if (!bus.wr_rd) rdata_d = mem_rdata;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (!wr_q) rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.ready = (state_q == RESP);
  assign bus.rdata = rdata_q;

endmodule
